// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared op codes and state encoding for the multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module : mdu_arith
// Brief  : Combinational {hi, lo} result for mult/multu/div/divu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_wr
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_div_s;
    logic [31:0] w_div_u;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [63:0] w_smul;
    logic [63:0] w_umul;

    assign w_a_neg = i_a[31];
    assign w_b_neg = i_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;

    // Divisor forced to 1 on zero so the dividers never see /0; the result is dropped.
    assign w_div_s = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_div_u = (i_b == 32'd0) ? 32'd1 : i_b;

    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
    assign w_q_mag = w_a_mag / w_div_s;
    assign w_r_mag = w_a_mag % w_div_s;
    assign w_q_s   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

    always_comb begin
        o_result = 64'd0;
        o_wr     = 1'b0;
        case (i_op)
            MD_MULT: begin
                o_result = w_smul;
                o_wr     = 1'b1;
            end
            MD_MULTU: begin
                o_result = w_umul;
                o_wr     = 1'b1;
            end
            MD_DIV: begin
                o_result = {w_r_s, w_q_s};
                o_wr     = (i_b != 32'd0);
            end
            MD_DIVU: begin
                o_result = {i_a % w_div_u, i_a / w_div_u};
                o_wr     = (i_b != 32'd0);
            end
            default: begin
                o_result = 64'd0;
                o_wr     = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module : mdu_ctrl
// Brief  : E-stage multiply/divide sequencer owning HI/LO, with D-stage stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  md_op_e,
    input  logic [31:0] a_e,
    input  logic [31:0] b_e,
    input  logic        md_instr_d,
    output logic        busy,
    output logic        start,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    md_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_phi, w_phi_nxt;
    logic [31:0]      r_plo, w_plo_nxt;
    logic             r_pwr, w_pwr_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;

    logic [63:0]      w_result;
    logic             w_result_wr;

    mdu_arith u_arith (
        .i_op     (md_op_e),
        .i_a      (a_e),
        .i_b      (b_e),
        .o_result (w_result),
        .o_wr     (w_result_wr)
    );

    assign busy     = (r_state == BUSY);
    assign start    = (r_state == IDLE) && is_muldiv(md_op_e);
    assign stall_md = md_instr_d & (busy | start);
    assign hi       = r_hi;
    assign lo       = r_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_pwr   <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phi   <= w_phi_nxt;
            r_plo   <= w_plo_nxt;
            r_pwr   <= w_pwr_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phi_nxt   = r_phi;
        w_plo_nxt   = r_plo;
        w_pwr_nxt   = r_pwr;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_phi_nxt   = w_result[63:32];
                    w_plo_nxt   = w_result[31:0];
                    w_pwr_nxt   = w_result_wr;
                    w_cnt_nxt   = is_mult(md_op_e) ? C_MULT_CNT : C_DIV_CNT;
                    w_state_nxt = BUSY;
                end else if (md_op_e == MD_MTHI) begin
                    w_hi_nxt = a_e;
                end else if (md_op_e == MD_MTLO) begin
                    w_lo_nxt = a_e;
                end
            end
            BUSY: begin
                // Any E-stage op arriving here is a protocol slip and is ignored.
                w_cnt_nxt = r_cnt - C_ONE;
                if (r_cnt == C_ONE) begin
                    if (r_pwr) begin
                        w_hi_nxt = r_phi;
                        w_lo_nxt = r_plo;
                    end
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module : tb_mdu_ctrl
// Brief  : Self-checking bench for mdu_ctrl against an arithmetic HI/LO model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  md_op_e = MD_NONE;
    logic [31:0] a_e = 32'd0;
    logic [31:0] b_e = 32'd0;
    logic        md_instr_d = 1'b0;
    logic        busy;
    logic        start;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_op_e    (md_op_e),
        .a_e        (a_e),
        .b_e        (b_e),
        .md_instr_d (md_instr_d),
        .busy       (busy),
        .start      (start),
        .stall_md   (stall_md),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural effect of an op on HI/LO, straight from the ISA rules.
    task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int              sa;
        int              sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = a;
        sb = b;
        ua = a;
        ub = b;
        case (op)
            MD_MULT: begin
                sp   = longint'(sa) * longint'(sb);
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MD_MULTU: begin
                up   = ua * ub;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic md_d, input logic intrude, input string tag);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
        old_hi = m_hi;
        old_lo = m_lo;
        n = (op == MD_MULT || op == MD_MULTU) ? MULT_N : DIV_N;
        @(negedge clk);
        md_op_e = op; a_e = a; b_e = b; md_instr_d = md_d;
        #1;
        chk({tag, ".start"}, 32'(start), 32'd1);
        chk({tag, ".stall0"}, 32'(stall_md), 32'(md_d));
        ref_apply(op, a, b);
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            md_op_e = intrude ? 3'($urandom_range(0, 7)) : MD_NONE;
            a_e = $urandom;
            b_e = $urandom;
            #1;
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".stall"}, 32'(stall_md), 32'(md_d));
            chk({tag, ".hi_hold"}, hi, old_hi);
            chk({tag, ".lo_hold"}, lo, old_lo);
            @(posedge clk);
            #1;
        end
        md_op_e = MD_NONE;
        #1;
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk({tag, ".stall_done"}, 32'(stall_md), 32'd0);
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input string tag);
        @(negedge clk);
        md_op_e = op; a_e = a; b_e = $urandom; md_instr_d = 1'b1;
        #1;
        chk({tag, ".start"}, 32'(start), 32'd0);
        chk({tag, ".stall"}, 32'(stall_md), 32'd0);
        ref_apply(op, a, 32'd0);
        @(posedge clk);
        #1;
        md_op_e = MD_NONE;
        #1;
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        md_instr_d = 1'b1;
        #2;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.start", 32'(start), 32'd0);
        chk("rst.stall", 32'(stall_md), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        md_instr_d = 1'b0;

        run_md(MD_MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, 1'b0, "mult");
        chk("mult.hi_const", hi, 32'hFFFF_FFFF);
        chk("mult.lo_const", lo, 32'hFFFF_FFFA);
        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu");
        chk("multu.hi_const", hi, 32'hFFFF_FFFE);
        chk("multu.lo_const", lo, 32'h0000_0001);
        run_md(MD_DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, 1'b0, "div");
        chk("div.hi_const", hi, 32'hFFFF_FFFF);
        chk("div.lo_const", lo, 32'hFFFF_FFFD);
        run_md(MD_DIVU,  32'd7,         32'd0,        1'b1, 1'b0, "divu0");
        chk("divu0.hi_const", hi, 32'hFFFF_FFFF);
        chk("divu0.lo_const", lo, 32'hFFFF_FFFD);
        run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        chk("div_ovf.hi_const", hi, 32'd0);
        chk("div_ovf.lo_const", lo, 32'h8000_0000);

        run_mt(MD_MTHI, 32'h1234_5678, "mthi");
        chk("mthi.hi_const", hi, 32'h1234_5678);
        run_mt(MD_MTLO, 32'hCAFE_BABE, "mtlo");
        chk("mtlo.lo_const", lo, 32'hCAFE_BABE);
        chk("mtlo.hi_kept", hi, 32'h1234_5678);

        // Reset pulse in the third busy cycle of a mult.
        @(negedge clk);
        md_op_e = MD_MULT; a_e = 32'd9; b_e = 32'd9; md_instr_d = 1'b0;
        @(posedge clk);
        #1;
        md_op_e = MD_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.hi", hi, 32'd0);
        chk("arst.lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        #3;
        rst_n = 1'b1;
        run_md(MD_MULT, 32'd1000, 32'hFFFF_FFF6, 1'b1, 1'b0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(1, 6));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (is_muldiv(r_op))
                run_md(r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'b1, "rnd");
            else
                run_mt(r_op, r_a, "rnd_mt");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
